// File: rtl/beat_detector.sv
// beat_detector: debounced intrinsic-heartbeat sense detector.
// Resynchronises sense_in, accepts a beat after DEBOUNCE_CYC consecutive
// high samples and blanks for REFRACT_CYC cycles after each beat. It then
// waits for the sense level to drop before it can accept the next beat.
// Optional interval measurement is enabled by defining BEAT_INTERVAL_MEAS_EN;
// without it, interval and interval_valid are tied to 0.
module beat_detector #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REFRACT_CYC  = 200,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sense_in,
  output logic             beat_pulse,
  output logic             in_refractory,
  output logic [CNT_W-1:0] interval,
  output logic             interval_valid
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, REFRACT, REARM} state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYC);
  localparam logic [15:0] REF_LOAD = 16'(REFRACT_CYC);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_t                 state_q, state_d;
  logic [7:0]             deb_cnt_q, deb_cnt_d;
  logic [15:0]            ref_cnt_q, ref_cnt_d;
  logic                   beat_pulse_q, beat_pulse_d;
  logic                   in_refr_q, in_refr_d;

  // Shift the raw pin into the synchroniser chain; only the last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sense_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic: debounce, refractory blanking and re-arm on a low level.
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    beat_pulse_d = 1'b0;
    in_refr_d    = (state_q == REFRACT);
    if (!ena) begin
      state_d   = IDLE;
      deb_cnt_d = 8'd0;
      ref_cnt_d = 16'd0;
      in_refr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s) begin
            if (DEB_LAST == 8'd1) begin
              beat_pulse_d = 1'b1;
              state_d      = REFRACT;
              ref_cnt_d    = REF_LOAD;
              deb_cnt_d    = 8'd0;
            end else begin
              state_d   = DEBOUNCE;
              deb_cnt_d = 8'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (!s) begin
            state_d   = IDLE;
            deb_cnt_d = 8'd0;
          end else if (deb_cnt_q + 8'd1 == DEB_LAST) begin
            beat_pulse_d = 1'b1;
            state_d      = REFRACT;
            ref_cnt_d    = REF_LOAD;
            deb_cnt_d    = 8'd0;
          end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
          end
        end
        REFRACT: begin
          if (ref_cnt_q <= 16'd1) begin
            state_d   = REARM;
            ref_cnt_d = 16'd0;
          end else begin
            ref_cnt_d = ref_cnt_q - 16'd1;
          end
        end
        REARM: begin
          if (!s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; reset aborts any beat in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      deb_cnt_q    <= 8'd0;
      ref_cnt_q    <= 16'd0;
      beat_pulse_q <= 1'b0;
      in_refr_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      beat_pulse_q <= beat_pulse_d;
      in_refr_q    <= in_refr_d;
    end
  end

  assign beat_pulse    = beat_pulse_q;
  assign in_refractory = in_refr_q;

`ifdef BEAT_INTERVAL_MEAS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;

  // Saturating beat-to-beat counter; the first beat only restarts the count.
  always_comb begin
    cnt_d      = cnt_q;
    interval_d = interval_q;
    valid_d    = valid_q;
    first_d    = first_q;
    if (!ena) begin
      valid_d = 1'b0;
      first_d = 1'b0;
    end else if (beat_pulse_d) begin
      if (first_q) begin
        interval_d = cnt_q;
        valid_d    = 1'b1;
      end
      first_d = 1'b1;
      cnt_d   = CNT_W'(1);
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Interval measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = valid_q;
`else
  assign interval       = '0;
  assign interval_valid = 1'b0;
`endif

endmodule
